mem_rsp: RTL

- Memory-side responder for the core's fetch/load/store request interface: the slave end that the instruction-fetch and load/store units initiate against.
- Accepts one request at a time over a valid/ready request channel and accesses an internal 64-bit-wide word array.
- Returns read data or a write acknowledge over a valid/ready response channel after a fixed, programmable latency.
- Replaces the zero-latency combinational memory, so the core is exercised against realistic multi-cycle memory.

---
 rtl/mem_rsp.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_rsp.sv
// mem_rsp: valid/ready memory responder over a 64-bit word array, one request in flight, fixed latency.
// Optional feature: define YSYX_23060251_MEM_RSP_RAND_DELAY_EN to add 0-3 LFSR-chosen extra wait cycles.
module mem_rsp #(
  parameter int                ADDR_W  = 32,
  parameter int                DEPTH   = 4096,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int                LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_wen_i,
  input  logic [63:0]       req_wdata_i,
  input  logic [7:0]        req_wmask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [63:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 4) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_load;
  logic              ready_q;
  logic              accept, resp_enter;

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wmask_q;

  logic [ADDR_W-1:0] cur_addr;
  logic              cur_wen;
  logic [63:0]       cur_wdata;
  logic [7:0]        cur_wmask;

  logic [ADDR_W-1:0] off, word_off;
  logic              err;
  logic [IDX_W-1:0]  idx;

  logic [63:0]       mem [DEPTH];
  logic [63:0]       rdata_q;
  logic              err_q;

`ifdef YSYX_23060251_MEM_RSP_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign cnt_load = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
  assign cnt_load = CNT_W'(LATENCY);
`endif

  assign accept = (state == IDLE) && ready_q && req_valid_i;

  // With zero wait cycles RESP is entered on the accept edge itself, before the request is latched.
  assign cur_addr  = (state == IDLE) ? req_addr_i  : addr_q;
  assign cur_wen   = (state == IDLE) ? req_wen_i   : wen_q;
  assign cur_wdata = (state == IDLE) ? req_wdata_i : wdata_q;
  assign cur_wmask = (state == IDLE) ? req_wmask_i : wmask_q;

  // Subtraction wraps in ADDR_W bits, so the explicit below-BASE test catches underflow.
  assign off      = cur_addr - BASE;
  assign word_off = off >> 3;
  assign err      = (cur_addr < BASE) || (word_off >= ADDR_W'(DEPTH));
  assign idx      = word_off[IDX_W-1:0];

  // NOTE: non-blocking assignments in clocked blocks keep every register sampling pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (cnt_load == '0) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_enter = (state != RESP) && (state_nxt == RESP);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_q <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        cnt     <= cnt_load;
        addr_q  <= req_addr_i;
        wen_q   <= req_wen_i;
        wdata_q <= req_wdata_i;
        wmask_q <= req_wmask_i;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (resp_enter) begin
        err_q   <= err;
        rdata_q <= (err || cur_wen) ? '0 : mem[idx];
      end
    end
  end

  // NOTE: the array has no reset; clearing it would need a per-word write port and it must survive reset.
  always_ff @(posedge clk_i) begin
    if (resp_enter && cur_wen && !err) begin
      for (int b = 0; b < 8; b++) begin
        if (cur_wmask[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    req_ready_o = ready_q && (state == IDLE);
    rsp_valid_o = (state == RESP);
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end

endmodule
